// File: rtl/alu_mem_sequencer_if.sv
// alu_mem_sequencer_if: command, loader, debug-read and status signals of
// the operand-fetch / write-back sequencer. The master drives commands and
// loads, and the slave (the sequencer) returns status and debug data.
interface alu_mem_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  // Command request
  logic              start;
  logic [2:0]        op;
  logic [ADDR_W-1:0] addr_a;
  logic [ADDR_W-1:0] addr_b;
  logic [ADDR_W-1:0] addr_d;
  // Memory loader
  logic              ld_en;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  // Debug read port
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;
  // Status
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] result;
  logic              zero;
  logic              ovf;
  logic              err;

  modport master (
    output start, op, addr_a, addr_b, addr_d,
    output ld_en, ld_addr, ld_data, dbg_addr,
    input  dbg_data, busy, done, result, zero, ovf, err
  );

  modport slave (
    input  start, op, addr_a, addr_b, addr_d,
    input  ld_en, ld_addr, ld_data, dbg_addr,
    output dbg_data, busy, done, result, zero, ovf, err
  );
endinterface

// File: rtl/alu_mem_sequencer.sv
// alu_mem_sequencer: operand-fetch / write-back stage around the AND, OR,
// ADD, SUBS, SOLT and NOR operations, with a DEPTH x DATA_W register memory.
// A command reads operand A, then operand B, computes op(A,B), writes the
// result to addr_d and pulses done.
// Optional feature macro: ALU_SAMEADDR_EN. When it is defined, a command whose
// addr_a equals its addr_b skips the second read, uses B = A, and completes
// one cycle earlier.
module alu_mem_sequencer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic               clk,
  input  logic               rst,
  alu_mem_sequencer_if.slave bus
);

  localparam int MSB = DATA_W - 1;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUBS = 3'b011;
  localparam logic [2:0] OP_SOLT = 3'b100;
  localparam logic [2:0] OP_NOR  = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD_A = 3'd1,
    S_RD_B = 3'd2,
    S_EXEC = 3'd3,
    S_WB   = 3'd4
  } state_t;

  state_t            r_state;
  logic              r_busy;
  logic              r_done;
  logic [DATA_W-1:0] r_result;
  logic              r_zero;
  logic              r_ovf;
  logic              r_err;
  logic [2:0]        r_op;
  logic [ADDR_W-1:0] r_addr_a;
  logic [ADDR_W-1:0] r_addr_b;
  logic [ADDR_W-1:0] r_addr_d;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_rd_data;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [DATA_W-1:0] w_sum;
  logic [DATA_W-1:0] w_diff;
  logic [DATA_W-1:0] w_alu;
  logic              w_alu_ovf;
  logic              w_legal;
  logic [ADDR_W-1:0] w_rd_addr;
  logic              w_wb_we;
  logic              w_ld_we;

  // Combinational operation select on the captured operands
  always_comb begin
    w_sum     = r_a + r_b;
    w_diff    = r_a - r_b;
    w_alu     = '0;
    w_alu_ovf = 1'b0;
    w_legal   = 1'b1;
    case (r_op)
      OP_AND:  w_alu = r_a & r_b;
      OP_OR:   w_alu = r_a | r_b;
      OP_ADD: begin
        w_alu     = w_sum;
        w_alu_ovf = (r_a[MSB] == r_b[MSB]) && (w_sum[MSB] != r_a[MSB]);
      end
      OP_SUBS: begin
        w_alu     = w_diff;
        w_alu_ovf = (r_a[MSB] != r_b[MSB]) && (w_diff[MSB] != r_a[MSB]);
      end
      OP_SOLT: w_alu = {{(DATA_W-1){1'b0}}, (r_a < r_b)};
      OP_NOR:  w_alu = ~(r_a | r_b);
      default: w_legal = 1'b0;
    endcase
  end

  // Read address follows the fetch phase; write enables for write-back and loader.
  // A load is only possible while not busy, so it never collides with write-back.
  assign w_rd_addr = (r_state == S_RD_A) ? r_addr_a : r_addr_b;
  assign w_wb_we   = (r_state == S_WB) && w_legal;
  assign w_ld_we   = bus.ld_en && !r_busy;

  // Register memory: synchronous write, registered internal read (not reset)
  always_ff @(posedge clk) begin
    if (w_wb_we) begin
      r_mem[r_addr_d] <= w_alu;
    end else if (w_ld_we) begin
      r_mem[bus.ld_addr] <= bus.ld_data;
    end
    r_rd_data <= r_mem[w_rd_addr];
  end

  // Command sequencer: fetch A, fetch B, execute, write back, pulse done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_ovf    <= 1'b0;
      r_err    <= 1'b0;
      r_op     <= '0;
      r_addr_a <= '0;
      r_addr_b <= '0;
      r_addr_d <= '0;
      r_a      <= '0;
      r_b      <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_op     <= bus.op;
            r_addr_a <= bus.addr_a;
            r_addr_b <= bus.addr_b;
            r_addr_d <= bus.addr_d;
            r_busy   <= 1'b1;
            r_state  <= S_RD_A;
          end
        end
        S_RD_A: begin
`ifdef ALU_SAMEADDR_EN
          // Identical operand addresses need only one read
          r_state <= (r_addr_a == r_addr_b) ? S_EXEC : S_RD_B;
`else
          r_state <= S_RD_B;
`endif
        end
        S_RD_B: begin
          r_a     <= r_rd_data;
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_b <= r_rd_data;
`ifdef ALU_SAMEADDR_EN
          if (r_addr_a == r_addr_b) begin
            r_a <= r_rd_data;
          end
`endif
          r_state <= S_WB;
        end
        S_WB: begin
          if (w_legal) begin
            r_result <= w_alu;
            r_zero   <= (w_alu == '0);
            r_ovf    <= w_alu_ovf;
            r_err    <= 1'b0;
          end else begin
            r_err    <= 1'b1;
          end
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.dbg_data = r_mem[bus.dbg_addr];
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.result   = r_result;
  assign bus.zero     = r_zero;
  assign bus.ovf      = r_ovf;
  assign bus.err      = r_err;

endmodule

// File: doc/alu_mem_sequencer.md
Name: alu_mem_sequencer

Overview:
- Operand-fetch / write-back stage wrapped around the team's combinational operation modules (AND, OR, ADD, SUBS, SOLT, NOR).
- Holds a DEPTH x DATA_W register memory.
- On a start command: reads operand A, then operand B; drives both into the selected operation; writes the result back to memory; pulses done.
- This is the "memory" half of the ALU-with-memory datapath: it feeds the operation modules and consumes their results.

Parameters:
- DATA_W, 32, operand/result width
- ADDR_W, 5, memory address width
- DEPTH, 32, number of memory words (must equal 2**ADDR_W)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  command request; sampled only in IDLE
- op  in  3  operation select, latched with start
- addr_a  in  ADDR_W  operand A address, latched with start
- addr_b  in  ADDR_W  operand B address, latched with start
- addr_d  in  ADDR_W  destination address, latched with start
- ld_en  in  1  loader write enable
- ld_addr  in  ADDR_W  loader write address
- ld_data  in  DATA_W  loader write data
- dbg_addr  in  ADDR_W  debug read address
- dbg_data  out  DATA_W  combinational mem[dbg_addr]
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse
- result  out  DATA_W  last computed result (registered)
- zero  out  1  result == 0, registered with result
- ovf  out  1  signed overflow; ADD/SUBS only, else 0
- err  out  1  illegal op on last command

Behaviour:
- Reset (async, immediate):
  - state=IDLE; busy=0, done=0, result=0, zero=0, ovf=0, err=0.
  - Memory contents are not cleared.
  - Reset mid-command aborts it: no write-back occurs and done is not asserted.
- Op encoding:
  - 000 AND, 001 OR, 010 ADD, 011 SUBS, 100 SOLT (unsigned A<B, result 1 or 0), 101 NOR.
  - 110/111 illegal.
- Arithmetic:
  - ADD/SUBS wrap modulo 2**DATA_W.
  - ovf = signed overflow: operand signs equal (ADD) or different (SUBS) and result sign differs from A.
- Memory:
  - Synchronous write.
  - Synchronous internal read, 1-cycle latency.
  - dbg_data is an asynchronous read.
- FSM (each arrow is one clock edge):
  - IDLE: start=1 -> latch op/addrs, go RD_A; busy=1 from the next cycle.
  - RD_A: read mem[addr_a] -> RD_B.
  - RD_B: capture A, read mem[addr_b] -> EXEC.
  - EXEC: capture B -> WB.
  - WB: write mem[addr_d] <= op(A,B); update result/zero/ovf; err=0; done=1; busy=0 -> IDLE.
  - Illegal op in WB: no memory write; result/zero/ovf hold their previous values; err=1; done=1.
- Latency: start sampled at edge 0; done high in the cycle after edge 4; busy high for the 4 cycles between.
- done: high exactly one cycle. A new start in that cycle is accepted.
- Inputs while busy:
  - start while busy=1 is ignored (not queued).
  - op/addr changes while busy have no effect.
- Loader:
  - ld_en is honoured only when busy=0; ignored otherwise.
  - ld_en and start in the same IDLE cycle: the load writes at edge 0. The operand read at edge 1 sees the new value (write-before-read ordering).
- addr_d may equal addr_a or addr_b. Operands are already captured before the write.
- err holds until the next completed command.

Optional Feature:
- Macro: ALU_SAMEADDR_EN.
- Defined: if the latched addr_a == addr_b, RD_B is skipped and B = A; done arrives one cycle earlier (edge 3). All other behaviour is unchanged.
- Undefined: always the full 4-edge sequence, regardless of addresses.

Test Plan:
- Load mem[1]=0x0000_0005, mem[2]=0x0000_0003; start op=010, a=1, b=2, d=3 -> done after edge 4; mem[3]=0x8, result=8, zero=0, ovf=0, busy high 4 cycles.
- Load mem[4]=0x7FFF_FFFF, mem[5]=0x1; ADD a=4, b=5, d=6 -> mem[6]=0x8000_0000, ovf=1. Then SUBS a=5, b=5, d=7 -> mem[7]=0, zero=1, ovf=0.
- SOLT with mem[1]=0x1, mem[8]=0xFFFF_FFFF (a=1, b=8) -> result=1 (unsigned). NOR with mem[1]=mem[2]=0 -> result=0xFFFF_FFFF.
- op=110, d=3 -> err=1, done pulses, mem[3] unchanged, result holds the previous value. A second start pulse during busy -> ignored, exactly one done.
- Assert rst in the EXEC state -> all outputs 0 immediately, mem[d] unchanged, no done. A subsequent command runs normally.
- a=b=2 with mem[2]=0x6, op=010 -> mem[d]=0xC; done after edge 3 with ALU_SAMEADDR_EN, after edge 4 without.
